// File: rtl/iscas_bist_ctrl.sv
// iscas_bist_ctrl
//
// BIST sequencer for an ISCAS89 benchmark core (s386 class). On a run
// request it flushes the core's unreset flip-flops with a fixed vector.
// It then drives 16-bit Fibonacci LFSR stimulus for a programmed number
// of cycles. Each of those cycles it compacts the core outputs into a
// 16-bit MISR, and it reports the final MISR value as the signature.
//
// Optional feature: define ISCAS_BIST_ABORT_EN to add the abort input.
// An abort in FLUSH or RUN returns to IDLE without a done pulse and
// leaves the previous signature in place.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   start      run request, sampled only in IDLE
//   cycles     number of measured RUN cycles, latched with start
//   busy       high in FLUSH and RUN
//   done       one-cycle pulse when a run completes
//   signature  MISR result, valid from done until the next run completes
//   stim       registered drive to the core inputs
//   resp       core outputs (combinational from stim and core state)
//   abort      (ISCAS_BIST_ABORT_EN only) cancel the current run
module iscas_bist_ctrl #(
  parameter int              IN_W         = 7,
  parameter int              OUT_W        = 7,
  parameter int              CNT_W        = 16,
  parameter int              FLUSH_CYCLES = 8,
  parameter logic [IN_W-1:0] FLUSH_VEC    = '0,
  parameter logic [15:0]     SEED         = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp
`ifdef ISCAS_BIST_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The flush counter only has to hold FLUSH_CYCLES-1.
  localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0]    m,
                                            input logic [OUT_W-1:0] r);
    return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ 16'(r);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      misr_q, misr_d;
  logic [15:0]      sig_q, sig_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic             abort_w;

`ifdef ISCAS_BIST_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    fcnt_d  = fcnt_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    sig_d   = sig_q;
    stim_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = cycles;
          lfsr_d  = SEED;
          misr_d  = '0;
          fcnt_d  = FC_LOAD;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // LFSR and MISR stay frozen here, so resp is ignored.
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (fcnt_q == '0) begin
          state_d = (rem_q == '0) ? S_DONE : S_RUN;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      S_RUN: begin
        // RUN is only entered with rem_q >= 1, so the decrement never wraps.
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          misr_d = misr_step(misr_q, resp);
          lfsr_d = lfsr_step(lfsr_q);
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The signature is captured on the edge into DONE so that it is
    // already valid while done is high.
    if (state_d == S_DONE) begin
      sig_d = misr_d;
    end

    // stim is registered, so it is derived from the next state and the
    // next LFSR value. That way each RUN cycle drives the LFSR word that
    // the MISR will pair with resp at the end of the same cycle.
    unique case (state_d)
      S_FLUSH: stim_d = FLUSH_VEC;
      S_RUN:   stim_d = lfsr_d[IN_W-1:0];
      default: stim_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      fcnt_q  <= '0;
      lfsr_q  <= SEED;
      misr_q  <= '0;
      sig_q   <= '0;
      stim_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      fcnt_q  <= fcnt_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      sig_q   <= sig_d;
      stim_q  <= stim_d;
    end
  end

  assign busy      = (state_q == S_FLUSH) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign signature = sig_q;
  assign stim      = stim_q;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
module tb_iscas_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cycles;
  logic        busy;
  logic        done;
  logic [15:0] signature;
  logic [6:0]  stim;
  logic [6:0]  resp;
  logic        abort;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iscas_bist_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cycles    (cycles),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .stim      (stim),
    .resp      (resp)
`ifdef ISCAS_BIST_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requests a run from IDLE. On return the bench is in cycle t+1, where
  // t is the edge that accepted start.
  task automatic launch(input logic [15:0] n);
    cycles = n;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Counts cycles from t+1 until done is seen. Returns -1 if done never
  // arrives within the budget.
  task automatic wait_done(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      if (done === 1'b1) begin
        k = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cycles = '0; resp = '0; abort = 1'b0;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL reset_sig got %h want 0000", signature); end
    checks++; if (stim !== 7'h00) begin errors++; $display("FAIL reset_stim got %h want 00", stim); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({busy, done, signature, stim} !== 25'd0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d got busy=%b done=%b sig=%h stim=%h want all 0",
                 i, busy, done, signature, stim);
      end
    end
  endtask

  task automatic test_misr();
    int k;
    resp = 7'h01;
    launch(16'd2);
    wait_done(40, k);
    checks++; if (k !== 11) begin errors++; $display("FAIL misr2_done_cycle got %0d want 11", k); end
    checks++; if (signature !== 16'h0003) begin errors++; $display("FAIL misr2_sig got %h want 0003", signature); end
    step();
    launch(16'd1);
    wait_done(40, k);
    checks++; if (k !== 10) begin errors++; $display("FAIL misr1_done_cycle got %0d want 10", k); end
    checks++; if (signature !== 16'h0001) begin errors++; $display("FAIL misr1_sig got %h want 0001", signature); end
    step();
    resp = 7'h00;
  endtask

  task automatic test_stim_sequence();
    logic [6:0] exp_stim;
    resp = 7'h00;
    launch(16'd3);
    for (int k = 1; k <= 12; k++) begin
      exp_stim = (k == 9) ? 7'h61 : (k == 10) ? 7'h43 : (k == 11) ? 7'h07 : 7'h00;
      checks++;
      if (stim !== exp_stim) begin errors++; $display("FAIL seq_stim cycle %0d got %h want %h", k, stim, exp_stim); end
      checks++;
      if (busy !== (k <= 11)) begin errors++; $display("FAIL seq_busy cycle %0d got %b want %b", k, busy, (k <= 11)); end
      checks++;
      if (done !== (k == 12)) begin errors++; $display("FAIL seq_done cycle %0d got %b want %b", k, done, (k == 12)); end
      if (k < 12) step();
    end
    checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL seq_sig got %h want 0000", signature); end
    step();
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL seq_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_zero_len();
    int k;
    int n_done;
    int first_k;
    logic [15:0] sig_at_done;
    // Leave a nonzero signature behind so the zero-length result is visible.
    resp = 7'h01;
    launch(16'd1);
    wait_done(40, k);
    checks++; if (signature !== 16'h0001) begin errors++; $display("FAIL zl_pre_sig got %h want 0001", signature); end
    step();
    resp = 7'h00;

    n_done = 0; first_k = -1; sig_at_done = 16'hFFFF;
    launch(16'd0);
    for (int c = 1; c <= 30; c++) begin
      if (done === 1'b1) begin
        n_done++;
        if (first_k < 0) begin first_k = c; sig_at_done = signature; end
      end
      if (c == 8) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zl_busy_flush got %b want 1", busy); end
      end
      if (c == 3) begin start = 1'b1; cycles = 16'd5; end
      if (c == 4) start = 1'b0;
      step();
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL zl_done_count got %0d want 1", n_done); end
    checks++; if (first_k !== 9) begin errors++; $display("FAIL zl_done_cycle got %0d want 9", first_k); end
    checks++; if (sig_at_done !== 16'h0000) begin errors++; $display("FAIL zl_sig got %h want 0000", sig_at_done); end
  endtask

  task automatic test_mid_run_reset();
    int k;
    int n_done;
    logic [6:0] exp_stim;
    resp = 7'h01;
    launch(16'd2);
    wait_done(40, k);
    checks++; if (signature !== 16'h0003) begin errors++; $display("FAIL mrr_pre_sig got %h want 0003", signature); end
    step();
    resp = 7'h00;

    launch(16'd3);
    for (int c = 1; c < 10; c++) step();
    checks++; if (stim !== 7'h43) begin errors++; $display("FAIL mrr_run2_stim got %h want 43", stim); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrr_busy got %b want 0", busy); end
    checks++; if (stim !== 7'h00) begin errors++; $display("FAIL mrr_stim got %h want 00", stim); end
    checks++; if (signature !== 16'h0000) begin errors++; $display("FAIL mrr_sig got %h want 0000", signature); end
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) n_done++;
      step();
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL mrr_no_done got %0d want 0", n_done); end

    launch(16'd3);
    for (int c = 1; c <= 12; c++) begin
      exp_stim = (c == 9) ? 7'h61 : (c == 10) ? 7'h43 : (c == 11) ? 7'h07 : 7'h00;
      checks++;
      if (stim !== exp_stim) begin errors++; $display("FAIL mrr_rerun_stim cycle %0d got %h want %h", c, stim, exp_stim); end
      if (c < 12) step();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mrr_rerun_done got %b want 1", done); end
    step();
  endtask

`ifdef ISCAS_BIST_ABORT_EN
  task automatic test_abort();
    int k;
    int n_done;
    resp = 7'h01;
    launch(16'd2);
    wait_done(40, k);
    checks++; if (signature !== 16'h0003) begin errors++; $display("FAIL ab_pre_sig got %h want 0003", signature); end
    step();
    resp = 7'h00;

    launch(16'd3);
    for (int c = 1; c < 10; c++) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_run_busy got %b want 1", busy); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b want 0", busy); end
    checks++; if (stim !== 7'h00) begin errors++; $display("FAIL ab_stim got %h want 00", stim); end
    checks++; if (signature !== 16'h0003) begin errors++; $display("FAIL ab_sig got %h want 0003", signature); end
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) n_done++;
      step();
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL ab_no_done got %0d want 0", n_done); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cycles = '0; resp = '0; abort = 1'b0;
    test_reset();
    test_misr();
    test_stim_sequence();
    test_zero_len();
    test_mid_run_reset();
`ifdef ISCAS_BIST_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iscas_bist_ctrl.md
# iscas_bist_ctrl

Built-in self-test sequencer for ISCAS89 benchmark cores (s386 class: 7 inputs, 7 outputs, unreset D flip-flops) mapped onto the fabric. It flushes the core's unreset state with a fixed vector, then drives LFSR pseudo-random stimulus for a programmed number of cycles. Each cycle it compacts the core's outputs into a MISR and reports a 16-bit signature with a start/done handshake. It sits between the test host (or on-chip CPU) and the benchmark core, and is the only driver of the core's inputs during a run.

## Interface
- `IN_W`, 7, DUT input width; 1..16.
- `OUT_W`, 7, DUT output width; 1..16.
- `CNT_W`, 16, width of the run-length count.
- `FLUSH_CYCLES`, 8, cycles of `FLUSH_VEC` applied before the measured run; must be ≥1.
- `FLUSH_VEC`, 0, stimulus held during flush; `IN_W` bits.
- `SEED`, 16'hACE1, LFSR reload value; must be nonzero.

- `clk`  in  1  sole clock; every register is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE.
- `cycles`  in  CNT_W  number of measured RUN cycles; latched when `start` is accepted.
- `busy`  out  1  high in FLUSH and RUN.
- `done`  out  1  one-cycle pulse when a run completes.
- `signature`  out  16  MISR result; valid from `done` until the next accepted `start`.
- `stim`  out  IN_W  registered drive to the DUT inputs.
- `resp`  in  OUT_W  DUT outputs; treated as combinational from `stim` and DUT state.
- `abort`  in  1  present only with `ISCAS_BIST_ABORT_EN`.

## Operation
- FSM states: IDLE → FLUSH → RUN → DONE → IDLE.
- **IDLE, `start`=1:** latch `cycles` into `remaining`; LFSR ← `SEED`; MISR ← 0; flush counter ← `FLUSH_CYCLES`-1; go to FLUSH. In any other state `start` is ignored.
- **FLUSH:** `stim` = `FLUSH_VEC`. LFSR and MISR are frozen; `resp` is ignored. When the counter reaches 0, go to RUN, or to DONE if `remaining`=0.
- **RUN:**
  - `stim` = LFSR[IN_W-1:0].
  - At each rising edge the MISR absorbs `resp`, the LFSR steps, and `remaining` decrements.
  - When `remaining` reaches 1 at the edge, go to DONE.
- **DONE:** `done`=1 for exactly one cycle; `signature` ← MISR; `stim` returns to 0; next state IDLE.
- **LFSR (Fibonacci):** fb = L[15]^L[13]^L[12]^L[10]; L ← {L[14:0], fb}.
- **MISR:** fb = M[15]^M[13]^M[12]^M[10]; M ← {M[14:0], fb} ^ zero-extend(`resp`).
- The counter is unsigned; `cycles`=2^CNT_W−1 is legal. No wrap-around occurs because the counter only ever counts down to the exit condition.
- **`rst` mid-run:** state returns to IDLE immediately. No `done` pulse is produced and `signature` clears to 0.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `signature`=0, `stim`=0, LFSR=`SEED`, MISR=0.
- **Start accepted at edge t:**
  - `busy` rises at t+1.
  - RUN spans t+1+`FLUSH_CYCLES` through t+`FLUSH_CYCLES`+N.
  - `done` is high during cycle t+`FLUSH_CYCLES`+N+1.
  - The earliest next `start` is accepted at the edge ending that `done` cycle+1 (IDLE).
- `stim` changes only at rising edges.
- `resp` is sampled at the end of the same cycle in which the matching `stim` is driven; zero latency is assumed.
- **Concurrent `start` and `rst`:** `rst` wins.

## Configuration
- **`ISCAS_BIST_ABORT_EN` defined:**
  - Adds the `abort` input.
  - `abort`=1 in FLUSH or RUN sends the FSM to IDLE at the next edge; `busy` falls and `stim` goes to 0.
  - No `done` pulse is produced, and `signature` keeps its previous value.
  - `abort` has no effect in IDLE or DONE.
  - If `abort` and the final RUN edge coincide, `abort` wins.
- **Undefined:** no `abort` port exists, and every accepted run ends in DONE.

## Test plan
- **Reset/idle:** after `rst`, `busy`, `done`, `signature` and `stim` are all 0. `start` is held low for 20 cycles and no output changes.
- **Stimulus sequence:** defaults, `cycles`=3, `resp` tied to 0.
  - `stim`=0 for 8 cycles, then 7'h61, 7'h43, …
  - `done` occurs at cycle t+12.
  - `signature`=16'h0000.
- **MISR arithmetic:** `cycles`=2, `resp`=7'h01 throughout RUN → `signature`=16'h0003. Repeat with `cycles`=1 → 16'h0001.
- **Zero length and busy-ignore:**
  - `cycles`=0 → FLUSH for 8 cycles, then `done` at t+9 with `signature`=0.
  - A second `start` pulsed during FLUSH is ignored: exactly one `done` is produced.
- **Mid-run reset:** `rst` asserted at the 2nd RUN cycle → IDLE next cycle, no `done`, `signature`=0. A fresh run afterwards reproduces the scenario-2 sequence.
- **Abort (macro on):** `abort` in RUN with a prior `signature`=16'h0003 → `busy` low next cycle, no `done`, `signature` stays 16'h0003.
